output_port_fifo: RTL and testbench
===================================

Name: output_port_fifo

Overview:
- Downstream consumer of the 3-input arbiter in each router output port.
- Uses the arbiter's one-hot grant to select one of three input-port flits and enqueues it into a small output FIFO.
- Drives the FIFO-full indication back to the arbiter.
- Presents flits to the link with a valid/ready handshake.

Parameters:
- FLIT_WIDTH, 16, width of one flit in bits.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy counter (derived, not overridden).

Ports:
- clk  input  1  clock, all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- grant_i  input  3  one-hot grant from the arbiter; bit n selects flit_i[n].
- grant_v_i  input  1  grant valid from the arbiter; qualifies grant_i.
- flit_i  input  3*FLIT_WIDTH  packed input-port flits; slice n = flit_i[n*FLIT_WIDTH +: FLIT_WIDTH].
- buffer_full_o  input to arbiter, output here  1  FIFO full; connects to the arbiter's buffer_full_i.
- data_o  output  FLIT_WIDTH  head flit of the FIFO.
- valid_o  output  1  head flit valid.
- ready_i  input  1  downstream link accepts the head flit this cycle.
- count_o  output  CNT_W  current occupancy.
- grant_err_o  output  1  sticky protocol-error flag.

Behaviour:
- Reset (async, rst=1):
  - wr_ptr=0, rd_ptr=0, count_o=0.
  - valid_o=0, buffer_full_o=0, grant_err_o=0.
  - data_o is don't-care; memory contents are not cleared.
- Push is attempted when grant_v_i=1.
  - Push succeeds when grant_v_i=1, grant_i is exactly one-hot, and buffer_full_o=0.
  - The selected slice is written to mem[wr_ptr]; wr_ptr increments, wrapping to 0 after DEPTH-1.
- Pop occurs when valid_o=1 and ready_i=1; rd_ptr increments with the same wrap rule.
- Pointers are $clog2(DEPTH) bits and wrap naturally.
- Occupancy: count_o next = count_o + push - pop.
  - Simultaneous push and pop leaves count_o unchanged.
  - Both pointers advance.
- Outputs are derived from registered state only (first-word fall-through):
  - valid_o = (count_o != 0).
  - data_o = mem[rd_ptr].
  - buffer_full_o = (count_o == DEPTH). It does not account for a same-cycle pop; this avoids a combinational loop through the arbiter.
- Latency: a flit pushed at edge N is visible on data_o with valid_o=1 after edge N when the FIFO was empty. There is no bypass path.
- Full boundary:
  - When count_o == DEPTH, a grant_v_i=1 attempt writes nothing.
  - Pointers and count are unchanged, and grant_err_o is set (overflow).
- Empty boundary: ready_i with count_o=0 has no effect.
- Invalid grant:
  - grant_v_i=1 with grant_i equal to 000 or having more than one bit set writes nothing and sets grant_err_o.
  - grant_i is ignored when grant_v_i=0.
- grant_err_o: once set, it stays 1 until reset. A pop in the same cycle still proceeds normally.
- Reset mid-operation: all state clears immediately (asynchronously), and in-flight flits are discarded.
- No other state machine; behaviour is fully defined by pointers, count, and the error flag.

Test Plan:
- Reset with rst=1 mid-stream after 3 pushes -> count_o=0, valid_o=0, buffer_full_o=0, grant_err_o=0 immediately, without waiting for a clock edge.
- Single push: grant_i=010, grant_v_i=1, flit_i slice1=16'hA5A5, ready_i=0 -> next cycle valid_o=1, data_o=A5A5, count_o=1. Then ready_i=1 for one cycle -> count_o=0, valid_o=0.
- Fill: 4 pushes with values 1,2,3,4 and ready_i=0 -> buffer_full_o=1, count_o=4. A 5th push attempt -> count_o stays 4 and grant_err_o=1. Draining yields 1,2,3,4 in order.
- Simultaneous push/pop at count_o=2 with ready_i=1 -> count_o stays 2 and ordering is preserved.
- Wrap-around: 10 push/pop interleavings across pointer wrap -> output sequence matches input sequence exactly, with no loss or duplication.
- Invalid grant: grant_v_i=1 with grant_i=011, then grant_i=000 -> no write, count_o unchanged, grant_err_o=1. grant_err_o stays 1 until rst.

Source files
------------

// File: rtl/output_port_fifo.sv
// Output-port flit FIFO: takes the arbiter-selected input flit on a valid one-hot grant
// and presents it to the link with first-word fall-through valid/ready.
module output_port_fifo #(
  parameter  int FLIT_WIDTH = 16,
  parameter  int DEPTH      = 4,
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              grant_i,
  input  logic                    grant_v_i,
  input  logic [3*FLIT_WIDTH-1:0] flit_i,
  output logic                    buffer_full_o,
  output logic [FLIT_WIDTH-1:0]   data_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [CNT_W-1:0]        count_o,
  output logic                    grant_err_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [FLIT_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count_r;
  logic                  err_r;

  logic                  one_hot;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic [FLIT_WIDTH-1:0] sel_flit;

  assign one_hot = (grant_i == 3'b001) || (grant_i == 3'b010) || (grant_i == 3'b100);
  assign full    = (count_r == CNT_W'(DEPTH));
  assign push    = grant_v_i && one_hot && !full;
  assign pop     = (count_r != '0) && ready_i;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    sel_flit = '0;
    unique case (grant_i)
      3'b001:  sel_flit = flit_i[0*FLIT_WIDTH +: FLIT_WIDTH];
      3'b010:  sel_flit = flit_i[1*FLIT_WIDTH +: FLIT_WIDTH];
      3'b100:  sel_flit = flit_i[2*FLIT_WIDTH +: FLIT_WIDTH];
      default: sel_flit = '0;
    endcase
  end

  // NOTE: the storage array is deliberately left out of reset; occupancy alone says what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sel_flit;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
      err_r   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count_r <= count_r + CNT_W'(push) - CNT_W'(pop);
      // Overflow or malformed grant is sticky until reset.
      if (grant_v_i && (!one_hot || full)) err_r <= 1'b1;
    end
  end

  // Full is from registered count only, so it never depends on ready_i within a cycle.
  assign buffer_full_o = full;
  assign valid_o       = (count_r != '0);
  assign data_o        = mem[rd_ptr];
  assign count_o       = count_r;
  assign grant_err_o   = err_r;

endmodule

// File: tb/tb_output_port_fifo.sv
// Scoreboard bench for output_port_fifo: driver queues expected flits, a negedge monitor
// compares every accepted head flit; directed checks cover count, full, error and reset.
module tb_output_port_fifo;

  localparam int FW    = 16;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [2:0]        grant_i = '0;
  logic              grant_v_i = 1'b0;
  logic [3*FW-1:0]   flit_i = '0;
  logic              buffer_full_o;
  logic [FW-1:0]     data_o;
  logic              valid_o;
  logic              ready_i = 1'b0;
  logic [CNT_W-1:0]  count_o;
  logic              grant_err_o;

  int assertions = 0;
  int failures   = 0;
  logic [FW-1:0] exp_q [$];

  output_port_fifo #(.FLIT_WIDTH(FW), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .grant_i       (grant_i),
    .grant_v_i     (grant_v_i),
    .flit_i        (flit_i),
    .buffer_full_o (buffer_full_o),
    .data_o        (data_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .count_o       (count_o),
    .grant_err_o   (grant_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: a handshake seen mid-cycle completes at the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          assertions++;
          failures++;
          $display("FAIL scoreboard_unexpected: got 0x%0h, expected no flit at %0t", data_o, $time);
        end else begin
          check("scoreboard_data", {16'h0, data_o}, {16'h0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  // One clock of stimulus; inputs change 1ns after a rising edge and return idle afterwards.
  task automatic cyc(input logic gv, input logic [2:0] g, input logic [FW-1:0] d, input logic rdy);
    grant_v_i = gv;
    grant_i   = g;
    ready_i   = rdy;
    for (int n = 0; n < 3; n++)
      flit_i[n*FW +: FW] = g[n] ? d : (16'hE000 + 16'(n));
    @(posedge clk); #1;
    grant_v_i = 1'b0;
    grant_i   = '0;
    ready_i   = 1'b0;
  endtask

  task automatic push_ok(input int slot, input logic [FW-1:0] d, input logic rdy);
    exp_q.push_back(d);
    cyc(1'b1, 3'(1 << slot), d, rdy);
  endtask

  task automatic pop_one();
    cyc(1'b0, 3'b000, 16'h0, 1'b1);
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_count", 32'(count_o), 0);
    check("rst_valid", 32'(valid_o), 0);
    check("rst_full", 32'(buffer_full_o), 0);
    check("rst_err", 32'(grant_err_o), 0);
    exp_q.delete();
    #2 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  int exp_cnt;

  initial begin
    // Power-on reset.
    #1;
    check("por_count", 32'(count_o), 0);
    check("por_valid", 32'(valid_o), 0);
    check("por_full", 32'(buffer_full_o), 0);
    check("por_err", 32'(grant_err_o), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // Single push through slot 1, then one pop.
    push_ok(1, 16'hA5A5, 1'b0);
    check("single_valid", 32'(valid_o), 1);
    check("single_data", 32'(data_o), 32'hA5A5);
    check("single_count", 32'(count_o), 1);
    pop_one();
    check("single_pop_count", 32'(count_o), 0);
    check("single_pop_valid", 32'(valid_o), 0);

    // Fill to DEPTH, overflow attempt, then drain in order.
    for (int i = 1; i <= 4; i++) push_ok(i % 3, 16'(i), 1'b0);
    check("fill_full", 32'(buffer_full_o), 1);
    check("fill_count", 32'(count_o), 4);
    check("fill_err", 32'(grant_err_o), 0);
    cyc(1'b1, 3'b001, 16'h0005, 1'b0);
    check("ovf_count", 32'(count_o), 4);
    check("ovf_err", 32'(grant_err_o), 1);
    check("ovf_head", 32'(data_o), 1);
    for (int i = 3; i >= 0; i--) begin
      pop_one();
      check("drain_count", 32'(count_o), 32'(i));
      check("drain_full", 32'(buffer_full_o), 0);
    end
    check("drain_err_sticky", 32'(grant_err_o), 1);

    // Reset mid-stream after three pushes clears everything without a clock edge.
    for (int i = 0; i < 3; i++) push_ok(i, 16'h0B00 + 16'(i), 1'b0);
    check("mid_count", 32'(count_o), 3);
    async_reset();
    check("post_rst_count", 32'(count_o), 0);

    // Simultaneous push and pop at occupancy 2.
    push_ok(0, 16'h0010, 1'b0);
    push_ok(1, 16'h0011, 1'b0);
    check("pp_pre_count", 32'(count_o), 2);
    push_ok(2, 16'h0012, 1'b1);
    check("pp_count", 32'(count_o), 2);
    check("pp_head", 32'(data_o), 32'h0011);
    pop_one();
    pop_one();
    check("pp_drained", 32'(count_o), 0);

    // Ten interleaved push/pop cycles across pointer wrap.
    exp_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      push_ok(i % 3, 16'h0100 + 16'(i), (i % 4) != 0);
      exp_cnt = exp_cnt + 1 - (((i % 4) != 0 && exp_cnt > 0) ? 1 : 0);
      check("wrap_count", 32'(count_o), 32'(exp_cnt));
    end
    while (exp_cnt > 0) begin
      pop_one();
      exp_cnt--;
    end
    check("wrap_empty", 32'(count_o), 0);

    // Invalid grants: no write, sticky error, pops still proceed.
    push_ok(0, 16'h0077, 1'b0);
    check("inv_err_clear", 32'(grant_err_o), 0);
    cyc(1'b1, 3'b011, 16'h0099, 1'b0);
    check("inv011_count", 32'(count_o), 1);
    check("inv011_err", 32'(grant_err_o), 1);
    cyc(1'b1, 3'b000, 16'h0099, 1'b0);
    check("inv000_count", 32'(count_o), 1);
    check("inv000_head", 32'(data_o), 32'h0077);
    cyc(1'b0, 3'b111, 16'h0099, 1'b0);
    check("gv0_count", 32'(count_o), 1);
    pop_one();
    check("inv_pop_count", 32'(count_o), 0);
    check("inv_err_sticky", 32'(grant_err_o), 1);
    async_reset();

    @(posedge clk); #1;
    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
